// File: rtl/dmem_responder_pkg.sv
// dmem_responder_pkg: FSM encoding, parameter defaults and counter width for the data-memory responder
package dmem_responder_pkg;
  localparam int LATENCY_DEF = 4;
  localparam int DEPTH_DEF = 256;
  localparam int CNT_W = 4;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
endpackage

// File: rtl/dmem_array.sv
// dmem_array: 1R1W word store, synchronous write, combinational read
module dmem_array import dmem_responder_pkg::*; #(
  parameter int DEPTH_WORDS = DEPTH_DEF,
  parameter int IW = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [IW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [IW-1:0] raddr,
  output logic [31:0]   rdata
);
  logic [31:0] mem [DEPTH_WORDS];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: fixed-latency data-memory responder that stalls the pipeline until the access completes
module dmem_responder import dmem_responder_pkg::*; #(
  parameter int LATENCY = LATENCY_DEF,
  parameter int DEPTH_WORDS = DEPTH_DEF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        stall_o,
  output logic        ack_o,
  output logic        err_o
);
  localparam int IW = $clog2(DEPTH_WORDS);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LATENCY > 1 ? LATENCY - 2 : 0);
  state_t state;
  logic [CNT_W-1:0] cnt;
  logic [31:0] addr_q, data_q, addr_e, data_e, rdata;
  logic rd_q, wr_q, rd_e, wr_e, req, idle_req, go_resp, fault, we;
  assign req = MemRead_i | MemWrite_i;
  assign idle_req = state == IDLE && req;
  assign stall_o = rst_i && (idle_req || state == WAIT);
  // with LATENCY=1 the response edge is also the request edge, so live inputs stand in for the latches
  assign go_resp = (idle_req && LATENCY == 1) || (state == WAIT && cnt == LAST);
  assign addr_e = state == IDLE ? addr_i : addr_q;
  assign data_e = state == IDLE ? data_i : data_q;
  assign rd_e = state == IDLE ? MemRead_i : rd_q;
  assign wr_e = state == IDLE ? MemWrite_i : wr_q;
  assign fault = |addr_e[1:0] || |addr_e[31:IW+2];
  assign we = rst_i && go_resp && wr_e && !fault;
  dmem_array #(.DEPTH_WORDS(DEPTH_WORDS), .IW(IW)) u_array (
    .clk(clk_i),
    .we(we),
    .waddr(addr_e[IW+1:2]),
    .wdata(data_e),
    .raddr(addr_e[IW+1:2]),
    .rdata(rdata)
  );
  always_ff @(posedge clk_i)
    if (idle_req) begin
      addr_q <= addr_i;
      data_q <= data_i;
      rd_q <= MemRead_i;
      wr_q <= MemWrite_i;
    end
  always_ff @(posedge clk_i)
    if (!rst_i) begin
      state <= IDLE;
      cnt <= '0;
      data_o <= '0;
      ack_o <= 1'b0;
      err_o <= 1'b0;
    end else begin
      ack_o <= go_resp;
      err_o <= go_resp && (fault || (rd_e && wr_e));
      if (go_resp && rd_e && !wr_e) data_o <= fault ? '0 : rdata;
      case (state)
        IDLE: if (req) begin
          state <= LATENCY == 1 ? RESP : WAIT;
          cnt <= '0;
        end
        WAIT: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST) state <= RESP;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter LATENCY, default 4, is the cycles from request visible to response delivered; legal range 1..15.
REQ-002 Parameter DEPTH_WORDS, default 256, is the number of 32-bit words stored; power of two, 4..4096.
REQ-003 clk_i  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_i  input  1  reset, synchronous, active-low.
REQ-005 MemRead_i  input  1  CPU read request, held stable by the CPU while stall_o=1.
REQ-006 MemWrite_i  input  1  CPU write request, held stable by the CPU while stall_o=1.
REQ-007 addr_i  input  32  byte address from the EX/MEM ALU result.
REQ-008 data_i  input  32  write data.
REQ-009 data_o  output  32  read data, registered.
REQ-010 stall_o  output  1  freeze request to the pipeline (PC, IF/ID, ID/EX, EX/MEM, MEM/WB).
REQ-011 ack_o  output  1  one-cycle pulse marking the response cycle.
REQ-012 err_o  output  1  one-cycle pulse with ack_o marking a faulted access.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, WAIT, RESP.
REQ-014 req = MemRead_i | MemWrite_i.
REQ-015 stall_o SHALL be combinational: 1 when (state=IDLE and req=1) or state=WAIT; 0 in RESP and in idle-without-request.
REQ-016 IDLE with req=1 SHALL latch addr_i, data_i and op; the next state is RESP if LATENCY=1, otherwise WAIT.
REQ-017 WAIT SHALL last exactly LATENCY-1 cycles, then go to RESP.
REQ-018 RESP SHALL last one cycle with ack_o=1 and stall_o=0, then always go to IDLE.
REQ-019 A request first visible in cycle T SHALL produce stall_o=1 in cycles T..T+LATENCY-1 and ack_o=1 in cycle T+LATENCY.
REQ-020 A request present in the cycle after RESP SHALL be treated as a new transaction, giving back-to-back accesses every LATENCY+1 cycles.
REQ-021 The word index SHALL be addr[log2(DEPTH_WORDS)+1:2].
REQ-022 An access SHALL fault when addr[1:0]!=0 or any address bit above the index is 1.
REQ-023 A non-faulting write SHALL update the array on the edge entering RESP.
REQ-024 A non-faulting read SHALL load data_o from the array on the edge entering RESP.
REQ-025 data_o SHALL hold its value until the next read response.
REQ-026 A faulting access SHALL not modify the array.
REQ-027 A faulting read SHALL set data_o=0.
REQ-028 A faulting access SHALL pulse err_o=1 in RESP.
REQ-029 MemRead_i=1 together with MemWrite_i=1 SHALL execute as a write and pulse err_o in RESP.
REQ-030 Request inputs changing or dropping during WAIT SHALL be ignored; the transaction completes with the latched values.
REQ-031 Read-after-write to the same word in consecutive transactions SHALL return the new data.

Reset
REQ-032 rst_i=0 at an edge SHALL force state IDLE, data_o=0 and the latency counter to 0.
REQ-033 stall_o, ack_o and err_o SHALL be 0 during reset.
REQ-034 Reset in WAIT SHALL abort the transaction; a pending write is discarded.
REQ-035 Array contents SHALL NOT be cleared by reset.
REQ-036 The first edge with rst_i=1 SHALL sample requests normally.

Structure
REQ-037 A shared package SHALL hold the state encoding (IDLE/WAIT/RESP), LATENCY and DEPTH_WORDS defaults, and the counter width (4 bits).
REQ-038 The storage SHALL be one sub-module, dmem_array, a 1R1W word array with synchronous write.
REQ-039 The FSM, latency counter and fault decode SHALL reside in dmem_responder.

Verification
REQ-040 Write: LATENCY=4, MemWrite_i, addr 0x10, data 0xDEADBEEF at T -> stall_o=1 in T..T+3, ack_o=1 at T+4, err_o=0.
REQ-041 Read-back: MemRead_i, addr 0x10 immediately after REQ-040 -> ack_o at T+9, data_o=0xDEADBEEF.
REQ-042 Fault: read of addr 0x13, then write of addr 0x400 with DEPTH 256 -> err_o=1 with each ack_o; read data_o=0; word 0 unchanged afterward.
REQ-043 Minimum latency: LATENCY=1, three back-to-back reads -> ack_o every second cycle; stall_o high only in each request's first cycle.
REQ-044 Reset abort: rst_i=0 at T+2 of a write of 0x12345678 to 0x20 -> stall_o=0 next cycle; a later read of 0x20 returns the previous contents.
REQ-045 Both requests: MemRead_i=MemWrite_i=1, addr 0x8, data 0x5 -> err_o=1 at ack_o; a later read of 0x8 returns 0x5.
